// File: rtl/decode_control_pkg.sv
// Shared constants and types for the multi-cycle RV64 decode/control block:
// stage codes, opcodes, ALU encodings, state enum and decode helpers.
package decode_control_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned INSN_W = 32;

    localparam logic [SEL_W-1:0] STAGE_FETCH     = 3'd0;
    localparam logic [SEL_W-1:0] STAGE_DECODE    = 3'd1;
    localparam logic [SEL_W-1:0] STAGE_EXECUTE   = 3'd2;
    localparam logic [SEL_W-1:0] STAGE_MEMORY    = 3'd3;
    localparam logic [SEL_W-1:0] STAGE_WRITEBACK = 3'd4;

    typedef enum logic [SEL_W-1:0] {
        S_FETCH     = STAGE_FETCH,
        S_DECODE    = STAGE_DECODE,
        S_EXECUTE   = STAGE_EXECUTE,
        S_MEMORY    = STAGE_MEMORY,
        S_WRITEBACK = STAGE_WRITEBACK
    } state_t;

    localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;

    // Register-file / ALU fields captured at instruction accept.
    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [ALU_W-1:0] alu_op;
    } dec_fields_t;

    function automatic logic opcode_supported(input logic [OPC_W-1:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_IALU) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // Unrecognised R-type funct3 values fall back to add.
    function automatic logic [ALU_W-1:0] alu_op_of(input logic [OPC_W-1:0] opc,
                                                   input logic [2:0]       funct3,
                                                   input logic             sub_bit);
        logic [ALU_W-1:0] op;
        op = ALU_ADD;
        if (opc == OPC_RTYPE) begin
            case (funct3)
                3'b000:  op = sub_bit ? ALU_SUB : ALU_ADD;
                3'b111:  op = ALU_AND;
                3'b110:  op = ALU_OR;
                default: op = ALU_ADD;
            endcase
        end else if (opc == OPC_BRANCH) begin
            op = ALU_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/decode_control_if.sv
// Instruction/memory handshake and decoded-control bundle of decode_control.
// slave is the control block, master is the fetch/datapath side.
interface decode_control_if
    import decode_control_pkg::*;
#(
    parameter int unsigned XLEN = 64
) ();
    logic                instr_valid;
    logic [INSN_W-1:0]   instr;
    logic                instr_ready;
    logic                mem_ready;
    logic [SEL_W-1:0]    sel;
    logic                Reg_Write;
    logic [REG_W-1:0]    Read_Register1;
    logic [REG_W-1:0]    Read_Register2;
    logic [REG_W-1:0]    Write_Register;
    logic [XLEN-1:0]     imm;
    logic [ALU_W-1:0]    alu_op;
    logic                mem_read;
    logic                mem_write;
    logic                illegal;

    modport master (
        output instr_valid, instr, mem_ready,
        input  instr_ready, sel, Reg_Write, Read_Register1, Read_Register2,
               Write_Register, imm, alu_op, mem_read, mem_write, illegal
    );

    modport slave (
        input  instr_valid, instr, mem_ready,
        output instr_ready, sel, Reg_Write, Read_Register1, Read_Register2,
               Write_Register, imm, alu_op, mem_read, mem_write, illegal
    );
endinterface

// File: rtl/decode_control_imm_gen.sv
// Combinational immediate generator: I/S/B formats sign-extended to XLEN,
// zero for R-type and unsupported opcodes.
module imm_gen
    import decode_control_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [OPC_W-1:0] opcode_i,
    input  logic [11:0]      hi_i,     // instr[31:20]
    input  logic [4:0]       lo_i,     // instr[11:7]
    output logic [XLEN-1:0]  imm_c_o
);

    always_comb begin
        imm_c_o = '0;
        case (opcode_i)
            OPC_IALU, OPC_LOAD: imm_c_o = XLEN'($signed(hi_i));
            OPC_STORE:          imm_c_o = XLEN'($signed({hi_i[11:5], lo_i}));
            OPC_BRANCH:         imm_c_o = XLEN'($signed({hi_i[11], lo_i[0], hi_i[10:5],
                                                         lo_i[4:1], 1'b0}));
            default:            imm_c_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_control.sv
// Multi-cycle RV64 subset control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// with a bounded memory wait and registered control outputs.
module decode_control
    import decode_control_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_control_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_t            state_q, state_d;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dec_fields_t       fld_q, fld_d;
    logic [XLEN-1:0]   imm_q, imm_d, imm_c;
    logic              rdy_q, rdy_d;
    logic              wr_q, wr_d;
    logic              mrd_q, mrd_d;
    logic              mwr_q, mwr_d;
    logic              ill_q, ill_d;
    logic              accept_c;
    logic              timeout_c;
    logic [OPC_W-1:0]  opc_q;

    assign opc_q = ir_q[OPC_W-1:0];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .opcode_i (ir_d[6:0]),
        .hi_i     (ir_d[31:20]),
        .lo_i     (ir_d[11:7]),
        .imm_c_o  (imm_c)
    );

    // Next state, IR/field capture and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        fld_d     = fld_q;
        imm_d     = imm_q;
        timeout_c = 1'b0;
        accept_c  = (state_q == S_FETCH) && rdy_q && bus.instr_valid;

        case (state_q)
            S_FETCH: begin
                if (accept_c) begin
                    ir_d    = bus.instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = opcode_supported(opc_q) ? S_EXECUTE : S_FETCH;
            end
            S_EXECUTE: begin
                case (opc_q)
                    OPC_RTYPE, OPC_IALU: state_d = S_WRITEBACK;
                    OPC_LOAD, OPC_STORE: state_d = S_MEMORY;
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                if (bus.mem_ready) begin
                    state_d = (opc_q == OPC_LOAD) ? S_WRITEBACK : S_FETCH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_FETCH;
                    timeout_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (accept_c) begin
            fld_d.rs1    = ir_d[19:15];
            fld_d.rs2    = ir_d[24:20];
            fld_d.rd     = ir_d[11:7];
            fld_d.alu_op = alu_op_of(ir_d[6:0], ir_d[14:12], ir_d[30]);
            imm_d        = imm_c;
        end

        rdy_d = (state_d == S_FETCH);
        wr_d  = (state_d == S_WRITEBACK);
        mrd_d = (state_d == S_MEMORY) && (ir_d[6:0] == OPC_LOAD);
        mwr_d = (state_d == S_MEMORY) && (ir_d[6:0] == OPC_STORE);
        ill_d = (accept_c && !opcode_supported(ir_d[6:0])) || timeout_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            fld_q   <= '0;
            imm_q   <= '0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fld_q   <= fld_d;
            imm_q   <= imm_d;
            rdy_q   <= rdy_d;
            wr_q    <= wr_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.sel            = state_q;
    assign bus.instr_ready    = rdy_q;
    assign bus.Reg_Write      = wr_q;
    assign bus.Read_Register1 = fld_q.rs1;
    assign bus.Read_Register2 = fld_q.rs2;
    assign bus.Write_Register = fld_q.rd;
    assign bus.alu_op         = fld_q.alu_op;
    assign bus.imm            = imm_q;
    assign bus.mem_read       = mrd_q;
    assign bus.mem_write      = mwr_q;
    assign bus.illegal        = ill_q;

endmodule

// File: tb/tb_decode_control.sv
// Self-checking bench for decode_control: table of instructions with expected
// fields/strobe counts/latency via a scoreboard queue, plus reset sequences.
module tb_decode_control;

    logic clk;
    logic rst_n;

    decode_control_if #(.XLEN(64)) bus ();

    decode_control #(.XLEN(64), .MEM_WAIT_MAX(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          wait_c;
        int          noise;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [3:0]  alu;
        int          ill;
        int          wb;
        int          mr;
        int          mw;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic [3:0]  alu;
        int          ill;
        int          wb;
        int          wb_bad;
        int          mr;
        int          mw;
        int          lat;
        int          unstable;
    } obs_t;

    localparam int NVEC = 15;

    vec_t vecs [NVEC];
    vec_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one instruction and watch it until the FSM is back in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int wait_c, input int noise,
                             input string tag, output obs_t o);
        int mc;
        bit cap;
        mc = 0;
        cap = 1'b0;
        o.rs1 = '0; o.rs2 = '0; o.rd = '0; o.imm = '0; o.alu = '0;
        o.ill = 0; o.wb = 0; o.wb_bad = 0; o.mr = 0; o.mw = 0; o.unstable = 0;
        o.lat = -1;
        @(negedge clk);
        check({tag, ".instr_ready"}, 64'(bus.instr_ready), 64'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        bus.mem_ready   = (noise != 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom();
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!cap && bus.sel == 3'd1) begin
                cap   = 1'b1;
                o.rs1 = bus.Read_Register1;
                o.rs2 = bus.Read_Register2;
                o.rd  = bus.Write_Register;
                o.imm = bus.imm;
                o.alu = bus.alu_op;
            end else if (cap && (bus.Read_Register1 != o.rs1 || bus.Read_Register2 != o.rs2 ||
                                 bus.Write_Register != o.rd || bus.imm != o.imm ||
                                 bus.alu_op != o.alu)) begin
                o.unstable++;
            end
            if (bus.illegal) o.ill++;
            if (bus.Reg_Write) begin
                if (bus.sel == 3'd4) o.wb++;
                else                 o.wb_bad++;
            end
            if (bus.mem_read)  o.mr++;
            if (bus.mem_write) o.mw++;
            if (bus.sel == 3'd3) begin
                mc++;
                bus.mem_ready = (mc == wait_c + 1);
            end else begin
                bus.mem_ready = (noise != 0);
            end
            if (bus.sel == 3'd0) begin
                o.lat = c;
                break;
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        obs_t  o;
        vec_t  e;
        string t;
        int    bad;

        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.mem_ready   = 1'b0;

        vecs[0]  = '{32'h002081B3, 0,    0, 5'd1,  5'd2,  5'd3,  64'd0,                  4'd0, 0, 1, 0,  0, 4};
        vecs[1]  = '{32'h406283B3, 0,    0, 5'd5,  5'd6,  5'd7,  64'd0,                  4'd1, 0, 1, 0,  0, 4};
        vecs[2]  = '{32'h00C5F533, 0,    0, 5'd11, 5'd12, 5'd10, 64'd0,                  4'd2, 0, 1, 0,  0, 4};
        vecs[3]  = '{32'h003160B3, 0,    1, 5'd2,  5'd3,  5'd1,  64'd0,                  4'd3, 0, 1, 0,  0, 4};
        vecs[4]  = '{32'h00208033, 0,    0, 5'd1,  5'd2,  5'd0,  64'd0,                  4'd0, 0, 1, 0,  0, 4};
        vecs[5]  = '{32'hFFF00213, 0,    0, 5'd0,  5'd31, 5'd4,  64'hFFFFFFFFFFFFFFFF,   4'd0, 0, 1, 0,  0, 4};
        vecs[6]  = '{32'h7FF48493, 0,    0, 5'd9,  5'd31, 5'd9,  64'd2047,               4'd0, 0, 1, 0,  0, 4};
        vecs[7]  = '{32'hFF813283, 2,    0, 5'd2,  5'd24, 5'd5,  64'hFFFFFFFFFFFFFFF8,   4'd0, 0, 1, 3,  0, 7};
        vecs[8]  = '{32'h0060B823, 1,    1, 5'd1,  5'd6,  5'd16, 64'd16,                 4'd0, 0, 0, 0,  2, 5};
        vecs[9]  = '{32'h0060B823, 0,    0, 5'd1,  5'd6,  5'd16, 64'd16,                 4'd0, 0, 0, 0,  1, 4};
        vecs[10] = '{32'h00208463, 0,    0, 5'd1,  5'd2,  5'd8,  64'd8,                  4'd1, 0, 0, 0,  0, 3};
        vecs[11] = '{32'hFE000FE3, 0,    0, 5'd0,  5'd0,  5'd31, 64'hFFFFFFFFFFFFFFFE,   4'd1, 0, 0, 0,  0, 3};
        vecs[12] = '{32'h0000007F, 0,    0, 5'd0,  5'd0,  5'd0,  64'd0,                  4'd0, 1, 0, 0,  0, 2};
        vecs[13] = '{32'hFF813283, 1000, 0, 5'd2,  5'd24, 5'd5,  64'hFFFFFFFFFFFFFFF8,   4'd0, 1, 0, 15, 0, 18};
        vecs[14] = '{32'hFF813283, 14,   0, 5'd2,  5'd24, 5'd5,  64'hFFFFFFFFFFFFFFF8,   4'd0, 0, 1, 15, 0, 19};

        // Reset state while rst_n is held low.
        @(negedge clk);
        @(negedge clk);
        check("rst.sel",         64'(bus.sel),            64'd0);
        check("rst.instr_ready", 64'(bus.instr_ready),    64'd0);
        check("rst.Reg_Write",   64'(bus.Reg_Write),      64'd0);
        check("rst.mem_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
        check("rst.illegal",     64'(bus.illegal),        64'd0);
        check("rst.imm",         bus.imm,                 64'd0);
        check("rst.regs",        64'({bus.Read_Register1, bus.Read_Register2, bus.Write_Register, bus.alu_op}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst.instr_ready", 64'(bus.instr_ready), 64'd1);
        check("post_rst.sel",         64'(bus.sel),         64'd0);

        for (int i = 0; i < NVEC; i++) begin
            sb_q.push_back(vecs[i]);
            t = $sformatf("v%0d", i);
            run_instr(vecs[i].instr, vecs[i].wait_c, vecs[i].noise, t, o);
            e = sb_q.pop_front();
            check({t, ".rs1"},      64'(o.rs1),      64'(e.rs1));
            check({t, ".rs2"},      64'(o.rs2),      64'(e.rs2));
            check({t, ".rd"},       64'(o.rd),       64'(e.rd));
            check({t, ".imm"},      o.imm,           e.imm);
            check({t, ".alu_op"},   64'(o.alu),      64'(e.alu));
            check({t, ".illegal"},  64'(o.ill),      64'(e.ill));
            check({t, ".wb"},       64'(o.wb),       64'(e.wb));
            check({t, ".wb_bad"},   64'(o.wb_bad),   64'd0);
            check({t, ".mem_rd"},   64'(o.mr),       64'(e.mr));
            check({t, ".mem_wr"},   64'(o.mw),       64'(e.mw));
            check({t, ".latency"},  64'(o.lat),      64'(e.lat));
            check({t, ".unstable"}, 64'(o.unstable), 64'd0);
        end

        // Reset asserted while a load waits in MEMORY.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = 32'hFF813283;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bad = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.sel == 3'd3) begin
                bad = 0;
                break;
            end
        end
        check("mrst.reached_mem", 64'(bad),          64'd0);
        check("mrst.mem_read_on", 64'(bus.mem_read), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.sel",      64'(bus.sel),      64'd0);
        check("mrst.mem_read", 64'(bus.mem_read), 64'd0);
        check("mrst.imm",      bus.imm,           64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.Reg_Write || bus.mem_read || bus.mem_write || bus.sel != 3'd0) bad++;
        end
        check("mrst.quiet_after", 64'(bad), 64'd0);

        sb_q.push_back(vecs[0]);
        run_instr(vecs[0].instr, 0, 0, "mrst.next", o);
        e = sb_q.pop_front();
        check("mrst.next.rd",      64'(o.rd),     64'(e.rd));
        check("mrst.next.wb",      64'(o.wb),     64'(e.wb));
        check("mrst.next.latency", 64'(o.lat),    64'(e.lat));
        check("mrst.next.wb_bad",  64'(o.wb_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
